clause_dispatch_arbiter: RTL and testbench
==========================================

# clause_dispatch_arbiter

Round-robin scheduler between the clause latency buffer and the `NUM_ENGINE` BCP engines. Each cycle it takes the consecutive clauses the buffer presents, assigns them to ready engines, and returns the consumed count so the buffer can advance its head. It sequences a propagation round through start, dispatch, drain, conflict and done.

## Interface
- `NUM_ENGINE`, default `` `NUM_ENGINE `` (4): number of engines and number of buffer output slots.
- `CNT_W`, default `$clog2(NUM_ENGINE)+1`: width of the released and received counts.
- `clock`  in  1  rising-edge clock; one clock domain.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `start_in`  in  1  begin a round; ignored unless state is IDLE.
- `clause_released_in`  in  CNT_W  number of valid buffer slots this cycle, 0..NUM_ENGINE; valid slots are 0..k-1.
- `clause_in`  in  cla_t[NUM_ENGINE]  buffer slots.
- `empty_in`  in  1  buffer holds no clauses.
- `engine_ready_in`  in  NUM_ENGINE  engine idle and able to accept a clause.
- `engine_conflict_in`  in  NUM_ENGINE  engine detected a conflict.
- `clause_received_out`  out  CNT_W  slots consumed this cycle; combinational.
- `engine_clause_out`  out  cla_t[NUM_ENGINE]  registered clause per engine.
- `engine_valid_out`  out  NUM_ENGINE  registered one-cycle strobe per engine.
- `busy_out`  out  1  state is DISPATCH or DRAIN.
- `done_out`  out  1  one-cycle pulse at the end of a round.
- `conflict_out`  out  1  sticky; set when a round ends on a conflict, cleared by the next accepted start.

## Operation
- States:
  - IDLE → DISPATCH on `start_in`.
  - DISPATCH → DRAIN when `empty_in` and `clause_released_in`==0.
  - DRAIN → DONE when all `engine_ready_in`=1 and `engine_valid_out`==0.
  - DONE → IDLE unconditionally after one cycle.
- Conflict: any `engine_conflict_in` bit in DISPATCH or DRAIN → DONE, and `conflict_out` is set.
- Eligible engine = `engine_ready_in[e]` && !`engine_valid_out[e]`. An engine granted last cycle is masked because its ready input lags by one cycle.
- Grant, in DISPATCH only:
  - Scan engines starting at `rr_ptr`, modulo NUM_ENGINE.
  - The j-th eligible engine found receives slot j, for j < `clause_released_in`.
  - `clause_received_out` = min(`clause_released_in`, eligible count).
  - Slots are consumed strictly in order; slots are never skipped.
- `rr_ptr` = (last granted engine + 1) mod NUM_ENGINE. It is unchanged when nothing is granted and resets to 0.
- In IDLE, DRAIN and DONE, `clause_received_out`=0 and no grants are issued.
- Arithmetic:
  - Counts are unsigned CNT_W.
  - `clause_released_in` > NUM_ENGINE is clamped to NUM_ENGINE.
  - The pointer wraps from NUM_ENGINE-1 to 0.

## Timing
- Reset values: state IDLE; `rr_ptr`=0; `engine_valid_out`=0; `engine_clause_out`=0; `busy_out`=0; `done_out`=0; `conflict_out`=0; `clause_received_out`=0.
- Reset is asynchronous. Assertion mid-round forces IDLE immediately and cancels any in-flight strobes.
- `clause_received_out` is valid in the same cycle as the buffer inputs. The buffer uses it in that cycle to advance its head.
- A grant in cycle N produces `engine_valid_out`/`engine_clause_out` in cycle N+1, one cycle wide.
- `done_out` is high for exactly the single cycle in which state = DONE.
- A `start_in` arriving in DONE is ignored, and the round does not restart.
- Simultaneous events:
  - Conflict and a grant in the same cycle: the grant still registers, and `clause_received_out` still reports it.
  - Conflict and empty in the same cycle: conflict wins and the next state is DONE.
- Buffer empty at start (`empty_in`=1, released=0): DISPATCH lasts one cycle, then DRAIN.

## Configuration
- `ARB_STATS_EN`: when defined, adds two outputs, both cleared on reset and on each accepted start, both saturating at all-ones:
  - `stat_dispatched_out`, 32-bit: sum of `clause_received_out` over the round.
  - `stat_stall_out`, 32-bit: DISPATCH cycles with released>0 and `clause_received_out`==0.
- When undefined, these ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- NUM_ENGINE=4, all engines ready, released=4 for 1 cycle → received=4; next cycle `engine_valid_out`=4'b1111 carrying slots 0..3; `rr_ptr`=0.
- Ready=4'b1010, `rr_ptr`=0, released=3 → received=2; engine1←slot0, engine3←slot1; `rr_ptr`=0.
- `rr_ptr`=2, all ready, released=1 → engine2←slot0; `rr_ptr`=3; same stimulus again → engine3←slot0; `rr_ptr` wraps to 0.
- Start with `empty_in`=1 and all engines ready → DISPATCH, DRAIN, then DONE; `done_out` pulses exactly 3 cycles after start; `conflict_out`=0.
- `engine_conflict_in`=4'b0100 in DISPATCH with released=2 → both slots granted and received=2; DONE next cycle; `conflict_out`=1 until the next start.
- Reset asserted while engine_valid=4'b0011 → outputs zero asynchronously; after release, state is IDLE and `start_in` is required to restart.

Source files
------------

// File: rtl/clause_dispatch_arbiter_if.sv
// Buffer-to-engine dispatch bus: the buffer/driver side uses master and the arbiter uses slave.
// The optional statistics outputs exist only when ARB_STATS_EN is defined.
`ifndef NUM_ENGINE
`define NUM_ENGINE 4
`endif

interface clause_dispatch_arbiter_if #(
    parameter int NUM_ENGINE = `NUM_ENGINE,
    parameter int CNT_W      = $clog2(NUM_ENGINE) + 1,
    parameter int CLA_W      = 24
);
    typedef struct packed {
        logic [CLA_W-9:0] addr;
        logic [7:0]       len;
    } cla_t;

    logic                   start_in;
    logic [CNT_W-1:0]       clause_released_in;
    cla_t [NUM_ENGINE-1:0]  clause_in;
    logic                   empty_in;
    logic [NUM_ENGINE-1:0]  engine_ready_in;
    logic [NUM_ENGINE-1:0]  engine_conflict_in;
    logic [CNT_W-1:0]       clause_received_out;
    cla_t [NUM_ENGINE-1:0]  engine_clause_out;
    logic [NUM_ENGINE-1:0]  engine_valid_out;
    logic                   busy_out;
    logic                   done_out;
    logic                   conflict_out;
`ifdef ARB_STATS_EN
    logic [31:0]            stat_dispatched_out;
    logic [31:0]            stat_stall_out;
`endif

    modport slave (
`ifdef ARB_STATS_EN
        output stat_dispatched_out, output stat_stall_out,
`endif
        input  start_in, input clause_released_in, input clause_in, input empty_in,
        input  engine_ready_in, input engine_conflict_in,
        output clause_received_out, output engine_clause_out, output engine_valid_out,
        output busy_out, output done_out, output conflict_out
    );

    modport master (
`ifdef ARB_STATS_EN
        input  stat_dispatched_out, input stat_stall_out,
`endif
        output start_in, output clause_released_in, output clause_in, output empty_in,
        output engine_ready_in, output engine_conflict_in,
        input  clause_received_out, input engine_clause_out, input engine_valid_out,
        input  busy_out, input done_out, input conflict_out
    );
endinterface

// File: rtl/clause_dispatch_arbiter.sv
// Round-robin clause dispatch from the latency buffer to BCP engines; consumed count is combinational,
// engine strobes follow one cycle after the grant; not-ready engines hold back slots. Optional ARB_STATS_EN.
`ifndef NUM_ENGINE
`define NUM_ENGINE 4
`endif

module clause_dispatch_arbiter #(
    parameter int NUM_ENGINE = `NUM_ENGINE,
    parameter int CNT_W      = $clog2(NUM_ENGINE) + 1,
    parameter int CLA_W      = 24
) (
    input  logic                       clock,
    input  logic                       reset,
    clause_dispatch_arbiter_if.slave   bus
);
    localparam int PTR_W = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_t;

    state_t                             r_state;
    logic [PTR_W-1:0]                   r_rr_ptr;
    logic [NUM_ENGINE-1:0]              r_valid;
    logic [NUM_ENGINE-1:0][CLA_W-1:0]   r_cla;
    logic                               r_busy;
    logic                               r_done;
    logic                               r_conflict;

    logic [NUM_ENGINE-1:0][CLA_W-1:0]   w_slot;
    logic [CNT_W-1:0]                   w_rel;
    logic [CNT_W-1:0]                   w_cnt;
    logic [NUM_ENGINE-1:0]              w_elig;
    logic [NUM_ENGINE-1:0]              w_grant;
    logic [NUM_ENGINE-1:0][PTR_W-1:0]   w_slot_idx;
    logic [PTR_W-1:0]                   w_last;
    logic [PTR_W-1:0]                   w_next_ptr;
    logic [PTR_W:0]                     w_idx;

    assign w_slot = bus.clause_in;
    // An engine strobed last cycle still shows ready, so it is masked for one cycle.
    assign w_elig = bus.engine_ready_in & ~r_valid;
    assign w_rel  = (bus.clause_released_in > CNT_W'(NUM_ENGINE)) ? CNT_W'(NUM_ENGINE)
                                                                   : bus.clause_released_in;

    always_comb begin
        w_cnt      = '0;
        w_grant    = '0;
        w_slot_idx = '0;
        w_last     = r_rr_ptr;
        w_idx      = '0;
        if (r_state == S_DISPATCH) begin
            for (int i = 0; i < NUM_ENGINE; i++) begin
                w_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
                if (w_idx >= (PTR_W+1)'(NUM_ENGINE))
                    w_idx = w_idx - (PTR_W+1)'(NUM_ENGINE);
                if (w_elig[w_idx[PTR_W-1:0]] && (w_cnt < w_rel)) begin
                    w_grant[w_idx[PTR_W-1:0]]    = 1'b1;
                    w_slot_idx[w_idx[PTR_W-1:0]] = w_cnt[PTR_W-1:0];
                    w_last                       = w_idx[PTR_W-1:0];
                    w_cnt                        = w_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign w_next_ptr = (w_last == PTR_W'(NUM_ENGINE - 1)) ? '0 : w_last + PTR_W'(1);

    assign bus.clause_received_out = w_cnt;
    assign bus.engine_clause_out   = r_cla;
    assign bus.engine_valid_out    = r_valid;
    assign bus.busy_out            = r_busy;
    assign bus.done_out            = r_done;
    assign bus.conflict_out        = r_conflict;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_valid    <= '0;
            r_cla      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_valid <= w_grant;
            for (int e = 0; e < NUM_ENGINE; e++)
                if (w_grant[e]) r_cla[e] <= w_slot[w_slot_idx[e]];
            if (|w_grant) r_rr_ptr <= w_next_ptr;

            case (r_state)
                S_IDLE: if (bus.start_in) begin
                    r_state    <= S_DISPATCH;
                    r_busy     <= 1'b1;
                    r_conflict <= 1'b0;
                end
                S_DISPATCH: if (|bus.engine_conflict_in) begin
                    r_state    <= S_DONE;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                    r_conflict <= 1'b1;
                end else if (bus.empty_in && (bus.clause_released_in == '0)) begin
                    r_state    <= S_DRAIN;
                end
                S_DRAIN: if (|bus.engine_conflict_in) begin
                    r_state    <= S_DONE;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                    r_conflict <= 1'b1;
                end else if ((&bus.engine_ready_in) && (r_valid == '0)) begin
                    r_state    <= S_DONE;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_done     <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] r_stat_disp;
    logic [31:0] r_stat_stall;
    logic [32:0] w_disp_sum;

    assign w_disp_sum              = {1'b0, r_stat_disp} + 33'(w_cnt);
    assign bus.stat_dispatched_out = r_stat_disp;
    assign bus.stat_stall_out      = r_stat_stall;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stat_disp  <= '0;
            r_stat_stall <= '0;
        end else if ((r_state == S_IDLE) && bus.start_in) begin
            r_stat_disp  <= '0;
            r_stat_stall <= '0;
        end else if (r_state == S_DISPATCH) begin
            r_stat_disp <= w_disp_sum[32] ? '1 : w_disp_sum[31:0];
            if ((bus.clause_released_in != '0) && (w_cnt == '0) && (r_stat_stall != '1))
                r_stat_stall <= r_stat_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_clause_dispatch_arbiter.sv
// Randomized scoreboard bench for clause_dispatch_arbiter: a driver predicts each cycle's outputs
// from a queue-level reference model, a negedge monitor pops and compares.
module tb_clause_dispatch_arbiter;
    localparam int N     = 4;
    localparam int CNT_W = 3;
    localparam int CLA_W = 24;
    localparam int W     = N * CLA_W;

    localparam int M_IDLE = 0, M_DISP = 1, M_DRAIN = 2, M_DONE = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    clause_dispatch_arbiter_if #(.NUM_ENGINE(N), .CNT_W(CNT_W), .CLA_W(CLA_W)) bus ();

    clause_dispatch_arbiter #(.NUM_ENGINE(N), .CNT_W(CNT_W), .CLA_W(CLA_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [CNT_W-1:0] rcv;
        logic [N-1:0]     vld;
        logic [W-1:0]     cla;
        logic             busy;
        logic             done;
        logic             conf;
        logic [31:0]      sd;
        logic [31:0]      ss;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int               m_state;
    int               m_ptr;
    logic [N-1:0]     m_vld;
    logic [CLA_W-1:0] m_cla [N];
    logic             m_conf;
    longint           m_sd, m_ss;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_ptr   = 0;
        m_vld   = '0;
        for (int i = 0; i < N; i++) m_cla[i] = '0;
        m_conf  = 1'b0;
        m_sd    = 0;
        m_ss    = 0;
    endtask

    // One clock of stimulus: drive inputs, record the outputs the model expects this cycle, advance.
    task automatic step(input bit st, input int rel, input bit emp, input logic [N-1:0] rdy,
                        input logic [N-1:0] cf, input bit rst);
        logic [W-1:0]     slots;
        logic [N-1:0]     nv;
        logic [CLA_W-1:0] ncla [N];
        exp_t             e;
        int               relc, n, last, eng;
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) slots[i*CLA_W +: CLA_W] = CLA_W'($urandom);
        bus.start_in           = st;
        bus.clause_released_in = CNT_W'(rel);
        bus.clause_in          = slots;
        bus.empty_in           = emp;
        bus.engine_ready_in    = rdy;
        bus.engine_conflict_in = cf;
        reset                  = !rst;
        if (rst) model_reset();

        relc = (rel > N) ? N : rel;
        n    = 0;
        last = -1;
        nv   = '0;
        for (int i = 0; i < N; i++) ncla[i] = m_cla[i];
        if (m_state == M_DISP) begin
            for (int off = 0; off < N; off++) begin
                eng = (m_ptr + off) % N;
                if (rdy[eng] && !m_vld[eng] && n < relc) begin
                    nv[eng]   = 1'b1;
                    ncla[eng] = slots[n*CLA_W +: CLA_W];
                    n++;
                    last = eng;
                end
            end
        end

        e.rcv  = CNT_W'(n);
        e.vld  = m_vld;
        for (int i = 0; i < N; i++) e.cla[i*CLA_W +: CLA_W] = m_cla[i];
        e.busy = (m_state == M_DISP) || (m_state == M_DRAIN);
        e.done = (m_state == M_DONE);
        e.conf = m_conf;
        e.sd   = m_sd[31:0];
        e.ss   = m_ss[31:0];
        q.push_back(e);

        if (!rst) begin
            if (m_state == M_IDLE && st) begin
                m_sd = 0;
                m_ss = 0;
            end else if (m_state == M_DISP) begin
                m_sd = (m_sd + n > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_sd + n;
                if (rel > 0 && n == 0 && m_ss < 64'hFFFF_FFFF) m_ss = m_ss + 1;
            end
            case (m_state)
                M_IDLE:  if (st) begin m_state = M_DISP; m_conf = 1'b0; end
                M_DISP:  if (cf != 0) begin m_state = M_DONE; m_conf = 1'b1; end
                         else if (emp && rel == 0) m_state = M_DRAIN;
                M_DRAIN: if (cf != 0) begin m_state = M_DONE; m_conf = 1'b1; end
                         else if (rdy == '1 && m_vld == '0) m_state = M_DONE;
                default: m_state = M_IDLE;
            endcase
            m_vld = nv;
            for (int i = 0; i < N; i++) m_cla[i] = ncla[i];
            if (n > 0) m_ptr = (last + 1) % N;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("received", W'(bus.clause_received_out), W'(e.rcv));
                chk("valid",    W'(bus.engine_valid_out),    W'(e.vld));
                chk("clause",   W'(bus.engine_clause_out),   e.cla);
                chk("busy",     W'(bus.busy_out),            W'(e.busy));
                chk("done",     W'(bus.done_out),            W'(e.done));
                chk("conflict", W'(bus.conflict_out),        W'(e.conf));
`ifdef ARB_STATS_EN
                chk("stat_disp",  W'(bus.stat_dispatched_out), W'(e.sd));
                chk("stat_stall", W'(bus.stat_stall_out),      W'(e.ss));
`endif
            end
        end
    end

    initial begin : driver
        bit           st, emp, rst;
        int           rel;
        logic [N-1:0] rdy, cf;
        bus.start_in = 1'b0; bus.clause_released_in = '0; bus.clause_in = '0;
        bus.empty_in = 1'b0; bus.engine_ready_in = '0; bus.engine_conflict_in = '0;
        model_reset();

        step(0, 0, 0, '1, '0, 1);
        step(0, 0, 0, '1, '0, 1);
        step(0, 0, 0, '1, '0, 0);
        // Full-width dispatch, partial ready, pointer walk and wrap.
        step(1, 0, 0, '1,      '0, 0);
        step(0, 4, 0, '1,      '0, 0);
        step(0, 0, 0, '1,      '0, 0);
        step(0, 3, 0, 4'b1010, '0, 0);
        step(0, 0, 0, '1,      '0, 0);
        step(0, 1, 0, 4'b0010, '0, 0);
        step(0, 0, 0, '1,      '0, 0);
        step(0, 1, 0, '1,      '0, 0);
        step(0, 1, 0, '1,      '0, 0);
        step(0, 1, 0, '1,      '0, 0);
        step(0, 7, 0, '1,      '0, 0);
        step(0, 0, 1, '1,      '0, 0);
        step(0, 0, 1, '1,      '0, 0);
        step(0, 0, 1, '1,      '0, 0);
        step(1, 0, 1, '1,      '0, 0);
        step(0, 0, 1, '1,      '0, 0);
        // Round on an empty buffer.
        step(1, 0, 1, '1, '0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, '1, '0, 0);
        // Conflict together with a two-slot grant.
        step(1, 0, 0, '1, '0,      0);
        step(0, 2, 0, '1, 4'b0100, 0);
        step(0, 0, 0, '1, '0,      0);
        step(0, 0, 0, '1, '0,      0);
        step(1, 0, 0, '1, '0,      0);
        // Reset while strobes are in flight, then no restart without start.
        step(0, 2, 0, 4'b0011, '0, 0);
        step(0, 0, 0, '1,      '0, 1);
        step(0, 4, 0, '1,      '0, 1);
        for (int i = 0; i < 3; i++) step(0, 4, 0, '1, '0, 0);

        for (int i = 0; i < 3000; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            emp = ($urandom_range(0, 5) == 0);
            rel = (emp && $urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, 7));
            rdy = N'($urandom);
            cf  = ($urandom_range(0, 39) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
            rst = ($urandom_range(0, 599) == 0);
            step(st, rel, emp, rdy, cf, rst);
        end

        repeat (3) @(negedge clock);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
